// File: rtl/sub_seq_ctrl.sv
// Sequences a WORDS x 16-bit subtraction through one shared 16-bit subtractor, LS word first.
// Optional ZERO/OVERFLOW flag outputs are built when SUB_SEQ_FLAGS_EN is defined.
module sub_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   op_a,
  input  logic [16*WORDS-1:0]   op_b,
  input  logic                  op_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   result,
  output logic                  borrow_out,
  output logic [15:0]           sub_a,
  output logic [15:0]           sub_b,
  output logic                  sub_bin,
  input  logic [15:0]           sub_res,
  input  logic                  sub_bout
`ifdef SUB_SEQ_FLAGS_EN
  ,
  output logic                  zero,
  output logic                  overflow
`endif
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [WORDS-1:0][15:0]  a_reg, b_reg, res_reg;
  logic                    bin_reg;
  logic                    borrow;
  logic                    bout_reg;
  logic [IW-1:0]           idx;
  logic                    last;

  assign last       = (idx == LAST);
  assign result     = res_reg;
  assign borrow_out = bout_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Subtractor inputs are forced to zero whenever the shared datapath is not ours.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sub_a     = 16'h0;
    sub_b     = 16'h0;
    sub_bin   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        sub_a   = a_reg[idx];
        sub_b   = b_reg[idx];
        sub_bin = (idx == '0) ? bin_reg : borrow;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg    <= '0;
      b_reg    <= '0;
      res_reg  <= '0;
      bin_reg  <= 1'b0;
      borrow   <= 1'b0;
      bout_reg <= 1'b0;
      idx      <= '0;
    end else if (state == IDLE && in_valid) begin
      a_reg   <= op_a;
      b_reg   <= op_b;
      bin_reg <= op_bin;
      idx     <= '0;
    end else if (state == RUN) begin
      res_reg[idx] <= sub_res;
      borrow       <= sub_bout;
      if (last) begin
        bout_reg <= sub_bout;
        idx      <= '0;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

`ifdef SUB_SEQ_FLAGS_EN
  logic zero_acc;
  logic zero_word;
  logic a_sign, b_sign;

  // Running AND of per-word zero tests; restarts on word 0.
  assign zero_word = ((idx == '0) | zero_acc) & (sub_res == 16'h0);
  assign a_sign    = a_reg[WORDS-1][15];
  assign b_sign    = b_reg[WORDS-1][15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_acc <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
    end else if (state == RUN) begin
      zero_acc <= zero_word;
      if (last) begin
        zero     <= zero_word;
        overflow <= (a_sign ^ b_sign) & (sub_res[15] ^ a_sign);
      end
    end
  end
`endif

endmodule
